// File: rtl/tk1_rewind_pkg.sv
// tk1_rewind_pkg: shared constants, state encoding and H-permutation table for the TK1 rewind engine
package tk1_rewind_pkg;
  localparam int TK_W = 64;
  localparam int STEPS_AD = 4;
  localparam int STEPS_MSG = 5;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN = 2'd1;
  localparam state_t DONE = 2'd2;
  // forward H: output nibble i takes input nibble PT[i]; nibble 0 is bits [63:60]
  localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
endpackage

// File: rtl/tk1_rewind_if.sv
// tk1_rewind_if: request/result bundle (start, ad, ncyc, tk1i in; tk1o, busy, done out)
interface tk1_rewind_if import tk1_rewind_pkg::*; #(parameter int CW = 6);
  logic start;
  logic ad;
  logic [CW-1:0] ncyc;
  logic [TK_W-1:0] tk1i;
  logic [TK_W-1:0] tk1o;
  logic busy;
  logic done;
  modport master(output start, ad, ncyc, tk1i, input tk1o, busy, done);
  modport slave(input start, ad, ncyc, tk1i, output tk1o, busy, done);
endinterface

// File: rtl/h_permutation_inv.sv
// h_permutation_inv: combinational inverse H-permutation; x = permuted TK1 in, y = un-permuted TK1 out
module h_permutation_inv import tk1_rewind_pkg::*; (
  input  logic [TK_W-1:0] x,
  output logic [TK_W-1:0] y
);
  // forward sends nibble PT[i] to slot i, so the inverse returns slot i to nibble PT[i]
  for (genvar i = 0; i < 16; i++) begin : g_cell
    assign y[TK_W-1-4*PT[i] -: 4] = x[TK_W-1-4*i -: 4];
  end
endmodule

// File: rtl/tk1_rewind.sv
// tk1_rewind: iterative TK1 rewind, removing 4 (ad=1) or 5 (ad=0) H-steps per cycle
// ports: clk, rst (async high); bus.start/ad/ncyc/tk1i request; bus.tk1o result, bus.busy in RUN, bus.done 1-cycle pulse
module tk1_rewind import tk1_rewind_pkg::*; #(
  parameter int CW = 6
) (
  input logic clk,
  input logic rst,
  tk1_rewind_if.slave bus
);
  state_t state, st_d, nxt;
  logic [CW-1:0] count;
  logic ad_r;
  logic accept;
  logic [TK_W-1:0] tk1_r;
  logic [TK_W-1:0] st [0:STEPS_MSG];
  logic [TK_W-1:0] step;
  // the unused code 2'd3 behaves as IDLE
  assign st_d = (state == 2'd3) ? IDLE : state;
  assign accept = bus.start && (st_d == IDLE || st_d == DONE);
  assign st[0] = tk1_r;
  for (genvar k = 0; k < STEPS_MSG; k++) begin : g_chain
    h_permutation_inv u_inv (.x(st[k]), .y(st[k+1]));
  end
  assign step = ad_r ? st[STEPS_AD] : st[STEPS_MSG];
  assign bus.tk1o = tk1_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (st_d == RUN) ? ((count == CW'(1)) ? DONE : RUN)
        : accept ? ((bus.ncyc != '0) ? RUN : DONE) : IDLE;
  end
  always_comb begin
    bus.busy = (st_d == RUN);
    bus.done = (st_d == DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tk1_r <= '0;
      count <= '0;
      ad_r <= 1'b0;
    end else if (accept) begin
      tk1_r <= bus.tk1i;
      count <= bus.ncyc;
      ad_r <= bus.ad;
    end else if (st_d == RUN) begin
      tk1_r <= step;
      count <= count - CW'(1);
    end
endmodule
